// File: rtl/collector.sv
// collector: receives NoC beats, keeps only tag-2 beats in a show-ahead
// receive buffer and reports packet completion and length.
//
// Ports
//    clk             rising-edge clock
//    rst             asynchronous reset, active low
//    axis_rx_tvalid  beat valid
//    axis_rx_tdata   beat, {tuser, payload}; tag lives in tuser[10:9]
//    axis_rx_tlast   last beat of packet
//    axis_rx_tready  buffer has room (from occupancy only)
//    out_valid       buffer head holds a beat
//    out_data        payload at buffer head
//    out_last        tlast stored with the head beat
//    out_ren         pop the head when out_valid is high
//    pkt_done        one-cycle pulse per completed packet
//    pkt_len         beat count of the last completed packet (saturating)
//    drop_count      number of rejected beats (saturating)
//
// Packet FSM
//    state  | meaning
//    IDLE   | no packet open, next valid beat starts one
//    IN_PKT | packet open, beat_cnt holds the beats accepted so far
module collector #(
   parameter int DATAW = 512,
   parameter int USERW = 75,
   parameter int DEPTH = 64,
   parameter int CNTW  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   axis_rx_tvalid,
   input  logic [DATAW+USERW-1:0] axis_rx_tdata,
   input  logic                   axis_rx_tlast,
   output logic                   axis_rx_tready,
   output logic                   out_valid,
   output logic [DATAW-1:0]       out_data,
   output logic                   out_last,
   input  logic                   out_ren,
   output logic                   pkt_done,
   output logic [CNTW-1:0]        pkt_len,
   output logic [CNTW-1:0]        drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic {IDLE, IN_PKT} state_t;

   logic [DATAW:0]  mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic [1:0]      tag;
   logic            accept, push, drop, pop;

   state_t          state, state_nxt;
   logic [CNTW-1:0] beat_cnt, cnt_nxt, cnt_inc;
   logic [CNTW-1:0] len_nxt;
   logic            done_nxt;

   // Header bits outside the tag are carried but not used here.
   logic unused_user;
   assign unused_user = ^axis_rx_tdata[DATAW+USERW-1:DATAW+11] ^ ^axis_rx_tdata[DATAW+8:DATAW];

   assign tag            = axis_rx_tdata[DATAW+10:DATAW+9];
   assign axis_rx_tready = (count < FULL);
   assign accept         = axis_rx_tvalid && axis_rx_tready;
   assign push           = accept && (tag == 2'h2);
   assign drop           = accept && (tag != 2'h2);
   assign out_valid      = (count != '0);
   assign pop            = out_valid && out_ren;
   assign {out_last, out_data} = mem[rd_ptr];

   // Pointers wrap for free because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {axis_rx_tlast, axis_rx_tdata[DATAW-1:0]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_count <= '0;
      end else if (drop && (drop_count != '1)) begin
         drop_count <= drop_count + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         beat_cnt <= '0;
         pkt_done <= 1'b0;
         pkt_len  <= '0;
      end else begin
         state    <= state_nxt;
         beat_cnt <= cnt_nxt;
         pkt_done <= done_nxt;
         pkt_len  <= len_nxt;
      end
   end

   assign cnt_inc = (beat_cnt == '1) ? beat_cnt : beat_cnt + 1'b1;

   // Only accepted tag-2 beats move the packet tracker.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = beat_cnt;
      done_nxt  = 1'b0;
      len_nxt   = pkt_len;
      if (push) begin
         case (state)
            IDLE: begin
               if (axis_rx_tlast) begin
                  done_nxt = 1'b1;
                  len_nxt  = CNTW'(1);
               end else begin
                  cnt_nxt   = CNTW'(1);
                  state_nxt = IN_PKT;
               end
            end
            IN_PKT: begin
               if (axis_rx_tlast) begin
                  done_nxt  = 1'b1;
                  len_nxt   = cnt_inc;
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_collector.sv
module tb_collector;
   localparam int DATAW = 32;
   localparam int USERW = 16;
   localparam int DEPTH = 64;
   localparam int CNTW  = 4;
   localparam int DU    = DATAW + USERW;
   localparam int CMAX  = (1 << CNTW) - 1;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            axis_rx_tvalid = 1'b0;
   logic [DU-1:0]   axis_rx_tdata = '0;
   logic            axis_rx_tlast = 1'b0;
   logic            axis_rx_tready;
   logic            out_valid;
   logic [DATAW-1:0] out_data;
   logic            out_last;
   logic            out_ren = 1'b0;
   logic            pkt_done;
   logic [CNTW-1:0] pkt_len;
   logic [CNTW-1:0] drop_count;

   always #5 clk = ~clk;

   collector #(.DATAW(DATAW), .USERW(USERW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst),
      .axis_rx_tvalid(axis_rx_tvalid), .axis_rx_tdata(axis_rx_tdata),
      .axis_rx_tlast(axis_rx_tlast), .axis_rx_tready(axis_rx_tready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .out_ren(out_ren), .pkt_done(pkt_done), .pkt_len(pkt_len),
      .drop_count(drop_count)
   );

   int vectors = 0;
   int miscompares = 0;
   int done_seen = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of stored beats plus packet/drop bookkeeping.
   typedef struct {
      logic [DATAW-1:0] d;
      logic             l;
   } beat_t;

   beat_t q[$];
   int    m_beats = 0;
   int    m_drop  = 0;
   int    m_len   = 0;
   logic  m_done  = 1'b0;
   bit    m_pop, m_acc;
   logic [1:0] m_tag;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
         m_beats = 0;
         m_drop  = 0;
         m_len   = 0;
         m_done  = 1'b0;
      end else begin
         m_pop  = (q.size() != 0) && out_ren;
         m_acc  = axis_rx_tvalid && (q.size() < DEPTH);
         m_tag  = axis_rx_tdata[DATAW+10 -: 2];
         m_done = 1'b0;
         if (m_pop) void'(q.pop_front());
         if (m_acc) begin
            if (m_tag == 2'h2) begin
               q.push_back('{d: axis_rx_tdata[DATAW-1:0], l: axis_rx_tlast});
               if (axis_rx_tlast) begin
                  m_done  = 1'b1;
                  m_len   = (m_beats + 1 > CMAX) ? CMAX : m_beats + 1;
                  m_beats = 0;
               end else begin
                  m_beats++;
               end
            end else if (m_drop < CMAX) begin
               m_drop++;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("tready", axis_rx_tready, q.size() < DEPTH);
      check("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
         check("out_data", out_data, q[0].d);
         check("out_last", out_last, q[0].l);
      end
      check("pkt_done", pkt_done, m_done);
      check("pkt_len", pkt_len, m_len);
      check("drop_count", drop_count, m_drop);
      if (pkt_done === 1'b1) done_seen++;
   end

   function automatic logic [DU-1:0] mk(input logic [1:0] tag, input logic [DATAW-1:0] p);
      logic [DU-1:0] d;
      d = '0;
      d[DATAW-1:0] = p;
      d[DATAW+10 -: 2] = tag;
      d[DU-1 -: 4] = 4'hA;
      d[DATAW+3:DATAW] = 4'h5;
      return d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] tag, input logic [DATAW-1:0] p, input logic last);
      axis_rx_tvalid = 1'b1;
      axis_rx_tdata  = mk(tag, p);
      axis_rx_tlast  = last;
      tick();
      axis_rx_tvalid = 1'b0;
      axis_rx_tlast  = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      out_ren = 1'b1;
      while (out_valid && n < 2 * DEPTH) begin
         tick();
         n++;
      end
      check(name, out_valid, 1'b0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_tready", axis_rx_tready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_pkt_len", pkt_len, 0);
      check("rst_drop", drop_count, 0);
      rst = 1'b1;

      // 3-beat packet, consumer always ready
      out_ren = 1'b1;
      done_seen = 0;
      send(2'h2, 32'h11, 1'b0);
      check("t1_head1", out_data, 32'h11);
      send(2'h2, 32'h22, 1'b0);
      check("t1_head2", out_data, 32'h22);
      check("t1_last2", out_last, 1'b0);
      send(2'h2, 32'h33, 1'b1);
      check("t1_head3", out_data, 32'h33);
      check("t1_last3", out_last, 1'b1);
      check("t1_done", pkt_done, 1'b1);
      repeat (3) tick();
      check("t1_done_count", done_seen, 1);
      check("t1_len", pkt_len, 3);

      // fill to DEPTH, 65th beat held off until one pop
      out_ren = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         axis_rx_tvalid = 1'b1;
         axis_rx_tdata  = mk(2'h2, 32'h1000 + i);
         axis_rx_tlast  = 1'b0;
         tick();
      end
      axis_rx_tdata = mk(2'h2, 32'h1040);
      axis_rx_tlast = 1'b1;
      check("t2_full_tready", axis_rx_tready, 1'b0);
      tick();
      check("t2_still_full", axis_rx_tready, 1'b0);
      out_ren = 1'b1;
      tick();
      out_ren = 1'b0;
      check("t2_tready_back", axis_rx_tready, 1'b1);
      check("t2_head", out_data, 32'h1001);
      tick();
      axis_rx_tvalid = 1'b0;
      axis_rx_tlast  = 1'b0;
      check("t2_full_again", axis_rx_tready, 1'b0);
      out_ren = 1'b1;
      repeat (DEPTH - 1) tick();
      check("t2_beat65", out_data, 32'h1040);
      check("t2_beat65_last", out_last, 1'b1);
      check("t2_len_sat", pkt_len, CMAX);
      drain("t2_drain");

      // tag-1 beats interleaved in a 4-beat packet
      done_seen = 0;
      send(2'h2, 32'h201, 1'b0);
      send(2'h1, 32'h2ee, 1'b0);
      send(2'h2, 32'h202, 1'b0);
      send(2'h1, 32'h2ef, 1'b1);
      send(2'h2, 32'h203, 1'b0);
      send(2'h2, 32'h204, 1'b1);
      repeat (2) tick();
      check("t3_drop", drop_count, 2);
      check("t3_len", pkt_len, 4);
      check("t3_done_count", done_seen, 1);

      // one entry in flight, push and pop every cycle
      out_ren = 1'b0;
      send(2'h2, 32'h300, 1'b0);
      out_ren = 1'b1;
      axis_rx_tvalid = 1'b1;
      axis_rx_tlast  = 1'b0;
      for (int i = 1; i <= 200; i++) begin
         axis_rx_tdata = mk(2'h2, 32'h300 + i);
         tick();
      end
      axis_rx_tvalid = 1'b0;
      check("t4_head", out_data, 32'h3c8);
      check("t4_occ", out_valid, 1'b1);
      drain("t4_drain");

      // reset in the middle of a packet
      out_ren = 1'b0;
      send(2'h2, 32'h501, 1'b0);
      send(2'h2, 32'h502, 1'b0);
      rst = 1'b0;
      #1;
      check("t5_rst_valid", out_valid, 1'b0);
      check("t5_rst_tready", axis_rx_tready, 1'b1);
      check("t5_rst_len", pkt_len, 0);
      repeat (2) tick();
      rst = 1'b1;
      done_seen = 0;
      send(2'h2, 32'h5aa, 1'b1);
      check("t5_head", out_data, 32'h5aa);
      out_ren = 1'b1;
      repeat (3) tick();
      check("t5_len", pkt_len, 1);
      check("t5_done_count", done_seen, 1);
      check("t5_empty", out_valid, 1'b0);

      // 20-beat packet with a 4-bit counter
      for (int i = 0; i < 20; i++) send(2'h2, 32'h600 + i, i == 19);
      repeat (2) tick();
      check("t6_len", pkt_len, 15);

      // drop counter saturation with tags 0 and 3
      for (int i = 0; i < 18; i++) send((i % 2) ? 2'h0 : 2'h3, 32'h700 + i, 1'b1);
      repeat (2) tick();
      check("t7_drop_sat", drop_count, 15);
      check("t7_len_kept", pkt_len, 15);
      check("t7_empty", out_valid, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/collector.md
COLLECTOR -- requirements
Module: collector

Interface
REQ-001 Parameter DATAW, default 512, payload width in bits.
REQ-002 Parameter USERW, default 75, header (tuser) width in bits; DATAUSERW = DATAW+USERW.
REQ-003 Parameter DEPTH, default 64, receive buffer entries, power of two, at least 4.
REQ-004 Parameter CNTW, default 16, width of all counters.
REQ-005 Port clk  input  1  single clock, rising-edge.
REQ-006 Port rst  input  1  asynchronous active-low reset; 0 = reset asserted.
REQ-007 Port axis_rx_tvalid  input  1  NoC beat valid.
REQ-008 Port axis_rx_tdata  input  DATAUSERW  NoC beat, {tuser, payload}.
REQ-009 Port axis_rx_tlast  input  1  last beat of packet.
REQ-010 Port axis_rx_tready  output  1  beat can be accepted.
REQ-011 Port out_valid  output  1  buffer head holds a beat.
REQ-012 Port out_data  output  DATAW  payload at buffer head.
REQ-013 Port out_last  output  1  tlast stored with head beat.
REQ-014 Port out_ren  input  1  consumer pops head when out_valid=1.
REQ-015 Port pkt_done  output  1  one-cycle pulse per completed packet.
REQ-016 Port pkt_len  output  CNTW  beat count of the most recently completed packet.
REQ-017 Port drop_count  output  CNTW  number of rejected beats, saturating.

Function
REQ-018 Accept a beat when axis_rx_tvalid=1 and axis_rx_tready=1 in the same cycle.
REQ-019 axis_rx_tready = 1 exactly when the buffer holds fewer than DEPTH entries; it is combinational from occupancy, not from tvalid.
REQ-020 Tag = axis_rx_tdata[DATAW+10:DATAW+9]; an accepted beat with tag 2'h2 is valid, any other tag is rejected.
REQ-021 A valid beat writes {tlast, payload} into the buffer; a rejected beat is discarded and drop_count increments by 1, holding at all-ones.
REQ-022 The buffer is a show-ahead FIFO: out_valid = not empty; out_data and out_last reflect the head entry combinationally.
REQ-023 A beat written at cycle N appears at out_valid/out_data at cycle N+1.
REQ-024 Pop occurs when out_valid=1 and out_ren=1; out_ren while empty has no effect.
REQ-025 Simultaneous push and pop leaves occupancy unchanged; read and write pointers wrap modulo DEPTH.
REQ-026 The packet FSM has states IDLE and IN_PKT and advances only on valid beats.
REQ-027 In IDLE, a valid beat with tlast=1 completes a packet of 1 beat; a valid beat with tlast=0 loads the beat counter with 1 and moves to IN_PKT.
REQ-028 In IN_PKT, a valid beat with tlast=0 increments the beat counter; a valid beat with tlast=1 completes a packet of counter+1 beats and returns to IDLE.
REQ-029 On completion, pkt_done pulses high for exactly the next cycle; in that same cycle pkt_len updates to the packet length and then holds until the next completion.
REQ-030 The beat counter saturates at all-ones, and pkt_len reports the saturated value.
REQ-031 Rejected beats do not change FSM state or the beat counter, even when they carry tlast=1.

Reset
REQ-032 While rst=0, immediately and independent of clk: buffer empty, pointers 0, out_valid=0, axis_rx_tready=1, FSM in IDLE, beat counter 0, pkt_done=0, pkt_len=0, drop_count=0.
REQ-033 Reset asserted mid-packet discards all buffered beats and the partial packet, and no pkt_done follows.
REQ-034 The first accept is possible on the first rising edge after rst returns to 1.

Verification
REQ-035 Send 3 tag-2 beats with tlast on beat 3, out_ren=1 -> outputs are 3 beats in order with out_last on beat 3 only; pkt_done is one pulse; pkt_len=3.
REQ-036 Hold out_ren=0 and present 65 beats with DEPTH=64 -> 64 are accepted; axis_rx_tready=0 on beat 65; one pop re-raises tready and beat 65 is then accepted with data intact.
REQ-037 Interleave beats with tag 2'h1 (one carrying tlast) within a 4-beat packet -> they do not reach out_data; drop_count equals the number of tag-1 beats; pkt_len=4.
REQ-038 Push and pop every cycle with the buffer at 1 entry for 200 cycles -> occupancy stays 1; pointers wrap; data order is preserved.
REQ-039 Drive rst=0 after 2 beats of a 5-beat packet, then release and send a 1-beat packet -> buffer is empty after reset; pkt_len=1; exactly one pkt_done.
REQ-040 With CNTW=4, send a 20-beat packet -> pkt_len=15.
